flash_bus_responder: RTL and testbench
======================================

# flash_bus_responder

Flash-side decoder for the NV-DDR control bus driven by the command translator: watches `cle`/`ale`/`wr`/`ce_n` each cycle, captures command, address and data-input bytes, and models ready/busy. It is the target end of the flash interface. It serves as the front end of the flash emulator used in controller bring-up and as a bus checker in system benches.

## Interface
- `ADDR_CYCLES`, 5: address bytes per full read or program address (column + row).
- `ROW_CYCLES`, 3: address bytes for an erase (row only); must be ≤ `ADDR_CYCLES`-1.
- `BUSY_CYCLES`, 16: `rb` low time after a confirm command, in clocks; must be ≥1.
- `clock_100`  in  1  system clock; all bus inputs are sampled on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ce_n`  in  1  chip enable, active low; bus is ignored while high.
- `cle`  in  1  command latch enable.
- `ale`  in  1  address latch enable.
- `wr`  in  1  W/R#: 1 = host drives DQ, 0 = flash drives DQ.
- `dq_in`  in  8  DQ byte captured from the DDR input register.
- `rb`  out  1  ready/busy#: 1 = ready.
- `cmd_valid`  out  1  one-cycle pulse; `cmd_byte` is valid.
- `cmd_byte`  out  8  last captured command.
- `addr_valid`  out  1  one-cycle pulse; `addr` is complete.
- `addr`  out  8*ADDR_CYCLES  assembled address; first address byte = bits [7:0].
- `din_valid`  out  1  one-cycle pulse per data-input byte.
- `din`  out  8  data-input byte.
- `dout_req`  out  1  high during each accepted data-output cycle.
- `error`  out  1  one-cycle pulse on a protocol violation.

## Operation
- Cycle decode, with `ce_n`=0 and `wr`=1:
  - `cle`=1, `ale`=0: command.
  - `cle`=0, `ale`=1: address.
  - `cle`=1, `ale`=1: data input.
- Cycle decode, other cases:
  - `cle`=1, `ale`=1, `wr`=0: data output.
  - `cle`=0, `ale`=0: idle (either `wr`).
  - Any other combination is illegal and pulses `error`.
  - `ce_n`=1 is idle regardless of the other inputs.
- States: IDLE, ADDR, DATA_IN, BUSY.
- Command capture (any state except BUSY):
  - Latch `cmd_byte` and pulse `cmd_valid`.
  - 0x00, 0x80, 0x60: clear the address counter and `addr`, go to ADDR, remember the opcode.
  - 0x30, 0x10, 0xD0 (confirm): go to BUSY, load the busy counter with `BUSY_CYCLES`.
  - 0xFF: go to BUSY; it aborts any sequence in progress.
  - 0x70: stay in state.
  - Any other opcode: accepted, no state change.
- Confirm after an incomplete address (no `addr_valid` since setup) pulses `error`; BUSY is still entered.
- ADDR:
  - Each address cycle writes `dq_in` into byte slot `n` and increments the counter.
  - Erase (0x60): the first row byte lands in slot `ADDR_CYCLES-ROW_CYCLES`; column slots stay 0.
  - Completion: `ADDR_CYCLES` bytes, or `ROW_CYCLES` for erase. On completion pulse `addr_valid`.
  - After completion: 0x80 goes to DATA_IN; 0x00 and 0x60 stay in ADDR, awaiting confirm.
  - Extra address cycles after completion pulse `error` and are discarded.
- DATA_IN:
  - Each data-input cycle pulses `din_valid` with `din` = `dq_in`.
  - A data-input cycle in any other state pulses `error` and is discarded.
- Data output:
  - Accepted in IDLE or ADDR (after read-confirm completion) and after 0x70 in any state: `dout_req`=1.
  - Data output while BUSY, except after 0x70, pulses `error`.
- BUSY:
  - `rb`=0; the counter decrements each cycle; at 0 go to IDLE and set `rb`=1.
  - Commands other than 0x70/0xFF pulse `error` and are ignored. 0xFF reloads the counter.
  - Address and data-input cycles pulse `error`.
- `ce_n` high mid-sequence does not reset state; the sequence resumes when it returns low.

## Timing
- All outputs are registered. Pulses and data appear 1 cycle after the sampling edge of the causing bus cycle.
- `rb` falls 1 cycle after the confirm is sampled and stays low exactly `BUSY_CYCLES` cycles.
- Reset, effective on the first edge with `rst`=1, overriding everything, including mid-BUSY:
  - `rb`=1.
  - All pulses 0.
  - `cmd_byte`=0, `addr`=0, `din`=0, `dout_req`=0.
  - State IDLE, counters 0.
- At most one of `cmd_valid`, `addr_valid`, `din_valid`, `dout_req` per cycle. `error` may coincide with `cmd_valid` only (incomplete-address confirm).

## Test plan
- Read: 0x00, 5 address bytes 0x11..0x55, 0x30 -> `addr_valid` with `addr`=0x5544332211. `rb` low 16 cycles starting 1 cycle after 0x30, then high.
- Program: 0x80, 5 address bytes, 4 data bytes 0xA0..0xA3, 0x10 -> four `din_valid` pulses in order, then `rb` low 16 cycles.
- Erase: 0x60, row bytes 0x01,0x02,0x03, 0xD0 -> `addr`=0x0302010000, `rb` low 16 cycles.
- Violations -> each pulses `error` once; `addr` and state unchanged:
  - 6th address byte during a read.
  - `cle`=0, `ale`=1, `wr`=0.
  - 0x80 while BUSY.
- 0xFF at busy cycle 10 -> counter reloads; `rb` stays low 16 further cycles. 0x70 then data output while BUSY -> `dout_req`=1, no `error`.
- `rst` asserted at busy cycle 5 -> next cycle `rb`=1, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/flash_bus_responder.sv
// Target-side decoder for the NV-DDR control bus: classifies each sampled bus cycle,
// captures command/address/data-input bytes and models the ready/busy# line.
module flash_bus_responder #(
    parameter int ADDR_CYCLES = 5,
    parameter int ROW_CYCLES  = 3,
    parameter int BUSY_CYCLES = 16
) (
    input  logic                     clock_100,
    input  logic                     rst,
    input  logic                     ce_n,
    input  logic                     cle,
    input  logic                     ale,
    input  logic                     wr,
    input  logic [7:0]               dq_in,
    output logic                     rb,
    output logic                     cmd_valid,
    output logic [7:0]               cmd_byte,
    output logic                     addr_valid,
    output logic [8*ADDR_CYCLES-1:0] addr,
    output logic                     din_valid,
    output logic [7:0]               din,
    output logic                     dout_req,
    output logic                     error
);

    localparam int ACW = $clog2(ADDR_CYCLES + 1);
    localparam int BCW = $clog2(BUSY_CYCLES + 1);

    localparam logic [7:0] OP_READ    = 8'h00;
    localparam logic [7:0] OP_PROGRAM = 8'h80;
    localparam logic [7:0] OP_ERASE   = 8'h60;
    localparam logic [7:0] OP_READ_GO = 8'h30;
    localparam logic [7:0] OP_PROG_GO = 8'h10;
    localparam logic [7:0] OP_ERASE_GO = 8'hD0;
    localparam logic [7:0] OP_RESET   = 8'hFF;
    localparam logic [7:0] OP_STATUS  = 8'h70;

    localparam logic [ACW-1:0] ERASE_BASE = ACW'(ADDR_CYCLES - ROW_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA_IN, ST_BUSY} state_t;
    typedef enum logic [2:0] {CYC_IDLE, CYC_CMD, CYC_ADDR, CYC_DIN, CYC_DOUT, CYC_BAD} cycle_t;

    state_t           state, state_next;
    cycle_t           kind;
    logic [ACW-1:0]   addr_cnt, addr_cnt_next;
    logic [BCW-1:0]   busy_cnt, busy_cnt_next;
    logic [7:0]       opcode, opcode_next;
    logic             addr_done, addr_done_next;
    logic             status_mode, status_mode_next;
    logic [7:0]       cmd_byte_next, din_next;
    logic [8*ADDR_CYCLES-1:0] addr_next;
    logic             cmd_valid_next, addr_valid_next, din_valid_next, dout_req_next, error_next;
    logic [ACW-1:0]   slot, need;

    always_comb begin
        kind = CYC_IDLE;
        if (!ce_n) begin
            case ({cle, ale})
                2'b10:   kind = wr ? CYC_CMD  : CYC_BAD;
                2'b01:   kind = wr ? CYC_ADDR : CYC_BAD;
                2'b11:   kind = wr ? CYC_DIN  : CYC_DOUT;
                default: kind = CYC_IDLE;
            endcase
        end
    end

    // Erase addresses are row-only, so they start above the column slots.
    assign slot = ((opcode == OP_ERASE) ? ERASE_BASE : '0) + addr_cnt;
    assign need = (opcode == OP_ERASE) ? ACW'(ROW_CYCLES) : ACW'(ADDR_CYCLES);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_next       = state;
        addr_cnt_next    = addr_cnt;
        busy_cnt_next    = busy_cnt;
        opcode_next      = opcode;
        addr_done_next   = addr_done;
        status_mode_next = status_mode;
        cmd_byte_next    = cmd_byte;
        addr_next        = addr;
        din_next         = din;
        cmd_valid_next   = 1'b0;
        addr_valid_next  = 1'b0;
        din_valid_next   = 1'b0;
        dout_req_next    = 1'b0;
        error_next       = 1'b0;

        if (state == ST_BUSY) begin
            busy_cnt_next = busy_cnt - BCW'(1);
            if (busy_cnt <= BCW'(1)) state_next = ST_IDLE;
        end

        case (kind)
            CYC_CMD: begin
                if (state == ST_BUSY && dq_in != OP_STATUS && dq_in != OP_RESET) begin
                    error_next = 1'b1;
                end else begin
                    cmd_valid_next   = 1'b1;
                    cmd_byte_next    = dq_in;
                    status_mode_next = (dq_in == OP_STATUS);
                    case (dq_in)
                        OP_READ, OP_PROGRAM, OP_ERASE: begin
                            state_next     = ST_ADDR;
                            opcode_next    = dq_in;
                            addr_cnt_next  = '0;
                            addr_next      = '0;
                            addr_done_next = 1'b0;
                        end
                        OP_READ_GO, OP_PROG_GO, OP_ERASE_GO: begin
                            state_next     = ST_BUSY;
                            busy_cnt_next  = BCW'(BUSY_CYCLES);
                            error_next     = !addr_done;
                            addr_done_next = 1'b0;
                        end
                        OP_RESET: begin
                            state_next     = ST_BUSY;
                            busy_cnt_next  = BCW'(BUSY_CYCLES);
                            addr_done_next = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            CYC_ADDR: begin
                if (state == ST_ADDR && !addr_done) begin
                    for (int i = 0; i < ADDR_CYCLES; i++) begin
                        if (slot == ACW'(i)) addr_next[i*8 +: 8] = dq_in;
                    end
                    addr_cnt_next = addr_cnt + ACW'(1);
                    if (addr_cnt + ACW'(1) == need) begin
                        addr_valid_next = 1'b1;
                        addr_done_next  = 1'b1;
                        if (opcode == OP_PROGRAM) state_next = ST_DATA_IN;
                    end
                end else begin
                    error_next = 1'b1;
                end
            end
            CYC_DIN: begin
                if (state == ST_DATA_IN) begin
                    din_valid_next = 1'b1;
                    din_next       = dq_in;
                end else begin
                    error_next = 1'b1;
                end
            end
            CYC_DOUT: begin
                if (status_mode || state == ST_IDLE || state == ST_ADDR) dout_req_next = 1'b1;
                else error_next = 1'b1;
            end
            CYC_BAD:  error_next = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clock_100) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state       <= ST_IDLE;
            addr_cnt    <= '0;
            busy_cnt    <= '0;
            opcode      <= '0;
            addr_done   <= 1'b0;
            status_mode <= 1'b0;
            rb          <= 1'b1;
            cmd_valid   <= 1'b0;
            cmd_byte    <= '0;
            addr_valid  <= 1'b0;
            addr        <= '0;
            din_valid   <= 1'b0;
            din         <= '0;
            dout_req    <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_next;
            addr_cnt    <= addr_cnt_next;
            busy_cnt    <= busy_cnt_next;
            opcode      <= opcode_next;
            addr_done   <= addr_done_next;
            status_mode <= status_mode_next;
            rb          <= (state_next != ST_BUSY);
            cmd_valid   <= cmd_valid_next;
            cmd_byte    <= cmd_byte_next;
            addr_valid  <= addr_valid_next;
            addr        <= addr_next;
            din_valid   <= din_valid_next;
            din         <= din_next;
            dout_req    <= dout_req_next;
            error       <= error_next;
        end
    end

endmodule

// File: tb/tb_flash_bus_responder.sv
// Directed bench for flash_bus_responder: read, program, erase, protocol violations,
// busy reload with status polling, and reset during busy.
module tb_flash_bus_responder;

    logic        clock_100 = 1'b0;
    logic        rst, ce_n, cle, ale, wr;
    logic [7:0]  dq_in;
    logic        rb, cmd_valid, addr_valid, din_valid, dout_req, error;
    logic [7:0]  cmd_byte, din;
    logic [39:0] addr;

    int checks = 0;
    int errors = 0;

    flash_bus_responder #(.ADDR_CYCLES(5), .ROW_CYCLES(3), .BUSY_CYCLES(16)) dut (
        .clock_100 (clock_100),
        .rst       (rst),
        .ce_n      (ce_n),
        .cle       (cle),
        .ale       (ale),
        .wr        (wr),
        .dq_in     (dq_in),
        .rb        (rb),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte),
        .addr_valid(addr_valid),
        .addr      (addr),
        .din_valid (din_valid),
        .din       (din),
        .dout_req  (dout_req),
        .error     (error)
    );

    always #5 clock_100 = ~clock_100;

    // {rb, cmd_valid, addr_valid, din_valid, dout_req, error}
    function automatic logic [5:0] flags();
        return {rb, cmd_valid, addr_valid, din_valid, dout_req, error};
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one bus cycle, let the DUT sample it, then settle past the edge.
    task automatic bus(input logic n_ce, input logic c, input logic a, input logic w, input logic [7:0] b);
        ce_n  = n_ce;
        cle   = c;
        ale   = a;
        wr    = w;
        dq_in = b;
        @(posedge clock_100);
        #1;
    endtask

    task automatic cmd(input logic [7:0] b);  bus(1'b0, 1'b1, 1'b0, 1'b1, b);     endtask
    task automatic adr(input logic [7:0] b);  bus(1'b0, 1'b0, 1'b1, 1'b1, b);     endtask
    task automatic dat(input logic [7:0] b);  bus(1'b0, 1'b1, 1'b1, 1'b1, b);     endtask
    task automatic dout();                    bus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00); endtask
    task automatic idle();                    bus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00); endtask

    // Counts further idle cycles with rb low before rb returns high (bounded).
    task automatic busy_run(input string tag, input int expected_low);
        int n = 0;
        for (int i = 0; i < 64; i++) begin
            idle();
            if (rb === 1'b1) break;
            n++;
        end
        check(tag, 64'(n), 64'(expected_low));
    endtask

    initial begin
        rst = 1'b1;
        ce_n = 1'b1; cle = 1'b0; ale = 1'b0; wr = 1'b0; dq_in = 8'h00;
        idle();
        idle();
        check("reset_flags", 64'(flags()), 64'(6'b100000));
        check("reset_addr", 64'(addr), 64'h0);
        rst = 1'b0;

        // Read
        cmd(8'h00);
        check("read_setup", 64'(flags()), 64'(6'b110000));
        check("read_cmd_byte", 64'(cmd_byte), 64'h00);
        for (int i = 1; i <= 4; i++) begin
            adr(8'(i * 17));
            check("read_addr_partial", 64'(flags()), 64'(6'b100000));
        end
        adr(8'h55);
        check("read_addr_valid", 64'(flags()), 64'(6'b101000));
        check("read_addr", 64'(addr), 64'h55_4433_2211);
        cmd(8'h30);
        check("read_confirm", 64'(flags()), 64'(6'b010000));
        busy_run("read_busy_len", 15);
        dout();
        check("read_dout_idle", 64'(flags()), 64'(6'b100010));

        // Violations
        cmd(8'h00);
        for (int i = 1; i <= 5; i++) adr(8'(i * 17));
        adr(8'h66);
        check("viol_extra_addr", 64'(flags()), 64'(6'b100001));
        check("viol_extra_addr_kept", 64'(addr), 64'h55_4433_2211);
        bus(1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
        check("viol_ale_wr0", 64'(flags()), 64'(6'b100001));
        check("viol_ale_wr0_addr", 64'(addr), 64'h55_4433_2211);
        cmd(8'h30);
        check("viol_confirm_ok", 64'(flags()), 64'(6'b010000));
        cmd(8'h80);
        check("viol_cmd_busy", 64'(flags()), 64'(6'b000001));
        check("viol_cmd_busy_byte", 64'(cmd_byte), 64'h30);
        busy_run("viol_busy_len", 14);

        // Program, with a deselected cycle in the middle of the address
        cmd(8'h80);
        check("prog_setup", 64'(flags()), 64'(6'b110000));
        adr(8'h01);
        adr(8'h02);
        bus(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
        check("prog_ce_high", 64'(flags()), 64'(6'b100000));
        adr(8'h03);
        adr(8'h04);
        adr(8'h05);
        check("prog_addr_valid", 64'(flags()), 64'(6'b101000));
        check("prog_addr", 64'(addr), 64'h05_0403_0201);
        for (int i = 0; i < 4; i++) begin
            dat(8'(8'hA0 + i));
            check("prog_din_flags", 64'(flags()), 64'(6'b100100));
            check("prog_din", 64'(din), 64'(8'hA0 + i));
        end
        cmd(8'h10);
        check("prog_confirm", 64'(flags()), 64'(6'b010000));
        busy_run("prog_busy_len", 15);

        // Erase
        cmd(8'h60);
        adr(8'h01);
        adr(8'h02);
        check("erase_partial", 64'(flags()), 64'(6'b100000));
        adr(8'h03);
        check("erase_addr_valid", 64'(flags()), 64'(6'b101000));
        check("erase_addr", 64'(addr), 64'h03_0201_0000);
        cmd(8'hD0);
        check("erase_confirm", 64'(flags()), 64'(6'b010000));
        busy_run("erase_busy_len", 15);

        // Confirm after an incomplete address
        cmd(8'h00);
        adr(8'hAA);
        adr(8'hBB);
        cmd(8'h30);
        check("short_confirm", 64'(flags()), 64'(6'b010001));
        busy_run("short_busy_len", 15);

        // 0xFF at busy cycle 10 reloads; 0x70 allows data output while busy
        cmd(8'h00);
        for (int i = 1; i <= 5; i++) adr(8'(i * 17));
        cmd(8'h30);
        repeat (8) idle();
        check("reload_still_busy", 64'(rb), 64'h0);
        cmd(8'hFF);
        check("reload_ff", 64'(flags()), 64'(6'b010000));
        cmd(8'h70);
        check("status_cmd", 64'(flags()), 64'(6'b010000));
        check("status_cmd_byte", 64'(cmd_byte), 64'h70);
        dout();
        check("status_dout", 64'(flags()), 64'(6'b000010));
        busy_run("reload_busy_len", 13);

        // Reset at busy cycle 5
        cmd(8'hFF);
        check("rst_ff", 64'(flags()), 64'(6'b010000));
        repeat (3) idle();
        rst = 1'b1;
        idle();
        check("rst_flags", 64'(flags()), 64'(6'b100000));
        check("rst_cmd_byte", 64'(cmd_byte), 64'h0);
        check("rst_addr", 64'(addr), 64'h0);
        check("rst_din", 64'(din), 64'h0);
        rst = 1'b0;
        dout();
        check("rst_idle_dout", 64'(flags()), 64'(6'b100010));
        adr(8'h12);
        check("rst_idle_addr_err", 64'(flags()), 64'(6'b100001));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
